// File: rtl/mem_if.sv
// Cache-to-memory line transfer bus between the cache controller (master)
// and the backing-store responder (slave).
interface mem_if;
  logic [8:0] addr_mem;
  logic       rd_mem;
  logic       wr_mem;
  logic [7:0] wdata_mem;
  logic [7:0] rdata_mem;
  logic       rvalid_mem;
  logic       ready_mem;

  modport master (
    output addr_mem, rd_mem, wr_mem, wdata_mem,
    input  rdata_mem, rvalid_mem, ready_mem
  );

  modport slave (
    input  addr_mem, rd_mem, wr_mem, wdata_mem,
    output rdata_mem, rvalid_mem, ready_mem
  );
endinterface

// File: rtl/mem_responder.sv
// Backing-store model for a 4-byte-line cache: 512 x 8 array serving line
// fills after a fixed latency and absorbing 4-beat line writebacks.
module mem_responder #(
  parameter int unsigned LATENCY = 3
) (
  input  logic  clock,
  input  logic  reset,
  mem_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_BURST, WR_WAIT} state_t;
  typedef logic [7:0] mem_t [512];

  localparam logic [3:0] LAT = 4'(LATENCY);

  function automatic mem_t init_image();
    mem_t img;
    for (int a = 0; a < 512; a++) img[a] = 8'(a);
    return img;
  endfunction

  mem_t       mem = init_image();
  state_t     state;
  logic [3:0] lat_cnt;
  logic [1:0] beat;
  logic [6:0] base;
  logic       ready;
  logic       rvalid;
  logic [7:0] rdata;
  logic       we;
  logic [8:0] waddr;
  logic       unused_offset;

  assign bus.ready_mem  = ready;
  assign bus.rvalid_mem = rvalid;
  assign bus.rdata_mem  = rdata;
  assign unused_offset  = ^bus.addr_mem[1:0];

  // Beat 0 of a writeback lands in the array at the acceptance edge itself.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    we    = 1'b0;
    waddr = '0;
    if (!reset) begin
      if (state == IDLE && bus.wr_mem) begin
        we    = 1'b1;
        waddr = {bus.addr_mem[8:2], 2'b00};
      end else if (state == WR_BURST) begin
        we    = 1'b1;
        waddr = {base, beat};
      end
    end
  end

  // NOTE: the array has no reset; contents survive reset, so only clock it.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= bus.wdata_mem;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ready   <= 1'b1;
      rvalid  <= 1'b0;
      rdata   <= 8'h00;
      lat_cnt <= '0;
      beat    <= '0;
      base    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.wr_mem) begin
            base  <= bus.addr_mem[8:2];
            beat  <= 2'd1;
            ready <= 1'b0;
            state <= WR_BURST;
          end else if (bus.rd_mem) begin
            base    <= bus.addr_mem[8:2];
            beat    <= 2'd0;
            lat_cnt <= LAT;
            ready   <= 1'b0;
            state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 4'd0) begin
            rvalid <= 1'b1;
            rdata  <= mem[{base, beat}];
            beat   <= beat + 2'd1;
            state  <= RD_BURST;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_BURST: begin
          // The 2-bit beat index wraps to 0 once beat 3 has been issued.
          if (beat == 2'd0) begin
            rvalid <= 1'b0;
            ready  <= 1'b1;
            state  <= IDLE;
          end else begin
            rdata <= mem[{base, beat}];
            beat  <= beat + 2'd1;
          end
        end
        WR_BURST: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3) begin
            lat_cnt <= LAT;
            state   <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (lat_cnt == 4'd0) begin
            ready <= 1'b1;
            state <= IDLE;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: LATENCY=3 and LATENCY=0 instances,
// read beats checked against per-instance expected-data queues.
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  mem_if ifa ();
  mem_if ifb ();

  mem_responder #(.LATENCY(3)) u_dut  (.clock(clock), .reset(reset), .bus(ifa));
  mem_responder #(.LATENCY(0)) u_dut0 (.clock(clock), .reset(reset), .bus(ifb));

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  // Scoreboards: every valid beat must match the oldest expected byte.
  always @(negedge clock) begin
    if (ifa.rvalid_mem === 1'b1) begin
      vectors++;
      if (qa.size() == 0) begin
        miscompares++;
        $display("FAIL beat_a unexpected beat got %h want none", ifa.rdata_mem);
      end else begin
        logic [7:0] e;
        e = qa.pop_front();
        if (ifa.rdata_mem !== e) begin
          miscompares++;
          $display("FAIL beat_a got %h want %h", ifa.rdata_mem, e);
        end
      end
    end
    if (ifb.rvalid_mem === 1'b1) begin
      vectors++;
      if (qb.size() == 0) begin
        miscompares++;
        $display("FAIL beat_b unexpected beat got %h want none", ifb.rdata_mem);
      end else begin
        logic [7:0] e;
        e = qb.pop_front();
        if (ifb.rdata_mem !== e) begin
          miscompares++;
          $display("FAIL beat_b got %h want %h", ifb.rdata_mem, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_a();
    ifa.rd_mem    = 1'b0;
    ifa.wr_mem    = 1'b0;
    ifa.addr_mem  = '0;
    ifa.wdata_mem = '0;
  endtask

  task automatic idle_b();
    ifb.rd_mem    = 1'b0;
    ifb.wr_mem    = 1'b0;
    ifb.addr_mem  = '0;
    ifb.wdata_mem = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_a();
    idle_b();
    tick();
    tick();
    vectors++;
    if (ifa.ready_mem !== 1'b1 || ifa.rvalid_mem !== 1'b0 || ifa.rdata_mem !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_a got ready=%b rvalid=%b rdata=%h want 1 0 00",
               ifa.ready_mem, ifa.rvalid_mem, ifa.rdata_mem);
    end
    vectors++;
    if (ifb.ready_mem !== 1'b1 || ifb.rvalid_mem !== 1'b0 || ifb.rdata_mem !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_b got ready=%b rvalid=%b rdata=%h want 1 0 00",
               ifb.ready_mem, ifb.rvalid_mem, ifb.rdata_mem);
    end
    reset = 1'b0;
  endtask

  // Line read on the LATENCY=3 instance; optionally scrambles the request
  // inputs for the whole time ready_mem is low.
  task automatic test_read(input logic [8:0] addr, input logic [31:0] beats,
                           input bit toggle, input string name);
    for (int i = 0; i < 4; i++) qa.push_back(beats[31-8*i -: 8]);
    ifa.rd_mem   = 1'b1;
    ifa.wr_mem   = 1'b0;
    ifa.addr_mem = addr;
    tick();
    vectors++;
    if (ifa.ready_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ready after E0 got %b want 0", name, ifa.ready_mem);
    end
    for (int k = 1; k <= 8; k++) begin
      if (toggle) begin
        ifa.rd_mem    = 1'($urandom);
        ifa.wr_mem    = 1'($urandom);
        ifa.addr_mem  = 9'($urandom);
        ifa.wdata_mem = 8'($urandom);
      end else begin
        idle_a();
      end
      tick();
      vectors++;
      if (ifa.rvalid_mem !== 1'(k >= 4 && k <= 7)) begin
        miscompares++;
        $display("FAIL %s rvalid after E0+%0d got %b want %b", name, k,
                 ifa.rvalid_mem, (k >= 4 && k <= 7));
      end
      vectors++;
      if (ifa.ready_mem !== 1'(k == 8)) begin
        miscompares++;
        $display("FAIL %s ready after E0+%0d got %b want %b", name, k,
                 ifa.ready_mem, (k == 8));
      end
    end
    idle_a();
    vectors++;
    if (qa.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing beats got %0d left want 0", name, qa.size());
      qa.delete();
    end
  endtask

  // Line writeback on the LATENCY=3 instance; with_rd also raises rd_mem at E0.
  task automatic test_write(input logic [8:0] addr, input logic [31:0] beats,
                            input bit with_rd, input string name);
    ifa.wr_mem    = 1'b1;
    ifa.rd_mem    = with_rd;
    ifa.addr_mem  = addr;
    ifa.wdata_mem = beats[31:24];
    tick();
    vectors++;
    if (ifa.ready_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL %s ready after E0 got %b want 0", name, ifa.ready_mem);
    end
    ifa.wr_mem = 1'b0;
    ifa.rd_mem = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      ifa.wdata_mem = beats[31-8*i -: 8];
      tick();
      vectors++;
      if (ifa.ready_mem !== 1'b0 || ifa.rvalid_mem !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after E0+%0d got ready=%b rvalid=%b want 0 0", name, i,
                 ifa.ready_mem, ifa.rvalid_mem);
      end
    end
    for (int k = 4; k <= 7; k++) begin
      ifa.wdata_mem = 8'($urandom);
      tick();
      vectors++;
      if (ifa.ready_mem !== 1'(k == 7) || ifa.rvalid_mem !== 1'b0) begin
        miscompares++;
        $display("FAIL %s after E0+%0d got ready=%b rvalid=%b want %b 0", name, k,
                 ifa.ready_mem, ifa.rvalid_mem, (k == 7));
      end
    end
    idle_a();
  endtask

  task automatic test_reset_abort();
    ifa.wr_mem    = 1'b1;
    ifa.addr_mem  = 9'h040;
    ifa.wdata_mem = 8'h01;
    tick();
    ifa.wr_mem    = 1'b0;
    ifa.wdata_mem = 8'h02;
    tick();
    ifa.wdata_mem = 8'h03;
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (ifa.ready_mem !== 1'b1 || ifa.rvalid_mem !== 1'b0 || ifa.rdata_mem !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_immediate got ready=%b rvalid=%b rdata=%h want 1 0 00",
               ifa.ready_mem, ifa.rvalid_mem, ifa.rdata_mem);
    end
    tick();
    tick();
    reset = 1'b0;
    idle_a();
    vectors++;
    if (ifa.ready_mem !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_release ready got %b want 1", ifa.ready_mem);
    end
    test_read(9'h040, 32'h0102_4243, 1'b0, "read_after_abort");
  endtask

  // LATENCY=0 instance with rd_mem held: two bursts one ready cycle apart.
  task automatic test_back_to_back();
    for (int n = 0; n < 2; n++) begin
      qb.push_back(8'hFC);
      qb.push_back(8'hFD);
      qb.push_back(8'hFE);
      qb.push_back(8'hFF);
    end
    ifb.rd_mem   = 1'b1;
    ifb.addr_mem = 9'h1FF;
    tick();
    vectors++;
    if (ifb.ready_mem !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b ready after E0 got %b want 0", ifb.ready_mem);
    end
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (k == 6) ifb.rd_mem = 1'b0;
      vectors++;
      if (ifb.rvalid_mem !== 1'((k >= 1 && k <= 4) || (k >= 7 && k <= 10))) begin
        miscompares++;
        $display("FAIL b2b rvalid after E0+%0d got %b want %b", k, ifb.rvalid_mem,
                 ((k >= 1 && k <= 4) || (k >= 7 && k <= 10)));
      end
      vectors++;
      if (ifb.ready_mem !== 1'(k == 5 || k == 11)) begin
        miscompares++;
        $display("FAIL b2b ready after E0+%0d got %b want %b", k, ifb.ready_mem,
                 (k == 5 || k == 11));
      end
    end
    idle_b();
    vectors++;
    if (qb.size() != 0) begin
      miscompares++;
      $display("FAIL b2b missing beats got %0d left want 0", qb.size());
      qb.delete();
    end
  endtask

  initial begin
    test_reset();
    test_read(9'h007, 32'h0405_0607, 1'b0, "read_basic");
    test_read(9'h007, 32'h0405_0607, 1'b1, "read_toggle");
    test_write(9'h093, 32'hAABB_CCDD, 1'b0, "write_basic");
    test_read(9'h090, 32'hAABB_CCDD, 1'b0, "read_back");
    test_write(9'h1F0, 32'h1122_3344, 1'b1, "write_collision");
    test_read(9'h1F0, 32'h1122_3344, 1'b0, "read_collision");
    test_reset_abort();
    test_back_to_back();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
